bot_state_loader: RTL

Synthesizable, parametrised loader that collects a state record (vx, vy, x, y) from each of `NUM_BOTS` robot channels through a valid/ack handshake. It converts each field from the wide input fixed-point format to the Q-format the motion datapath consumes. Once every bot has been captured in the current round, it publishes all records together as one coherent snapshot. It sits between the per-bot telemetry sources and the collision/velocity-update logic. `read_done` tells the downstream logic that a fresh snapshot is ready, and `output_check` requests the next round.

---
 rtl/bot_state_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bot_state_loader.sv
// bot_state_loader: gathers per-bot (vx, vy, x, y) records, converts them to Q-format and publishes one snapshot per round.
// Define BOT_LOADER_SAT_EN to clamp out-of-range values and report sat_flag; otherwise values wrap.
module bot_state_loader #(
  parameter int NUM_BOTS    = 3,
  parameter int IN_W        = 32,
  parameter int IN_FRAC     = 16,
  parameter int OUT_W       = 16,
  parameter int OUT_FRAC    = 11,
  parameter int DONE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      output_check,
  input  logic [NUM_BOTS-1:0]       bot_valid,
  input  logic [NUM_BOTS*IN_W-1:0]  bot_vx,
  input  logic [NUM_BOTS*IN_W-1:0]  bot_vy,
  input  logic [NUM_BOTS*IN_W-1:0]  bot_x,
  input  logic [NUM_BOTS*IN_W-1:0]  bot_y,
  output logic [NUM_BOTS-1:0]       bot_ack,
  output logic [NUM_BOTS*OUT_W-1:0] out_vx,
  output logic [NUM_BOTS*OUT_W-1:0] out_vy,
  output logic [NUM_BOTS*OUT_W-1:0] out_x,
  output logic [NUM_BOTS*OUT_W-1:0] out_y,
  output logic [NUM_BOTS-1:0]       sat_flag,
  output logic                      read_done
);
  localparam int SH = IN_FRAC - OUT_FRAC;
  localparam int XW = NUM_BOTS > 1 ? $clog2(NUM_BOTS) : 1;
  localparam int CW = $clog2(DONE_CYCLES + 1);
  localparam int FW = NUM_BOTS * OUT_W;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
`ifdef BOT_LOADER_SAT_EN
  // The shifted value fits OUT_W iff the input bits from the new sign bit upward all agree.
  function automatic logic ovf(input logic [IN_W-1:0] v);
    return !(&v[IN_W-1:OUT_W-1+SH] || !(|v[IN_W-1:OUT_W-1+SH]));
  endfunction
  function automatic logic [OUT_W-1:0] cvt(input logic [IN_W-1:0] v);
    return ovf(v) ? (v[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
                  : OUT_W'($signed(v) >>> SH);
  endfunction
`else
  function automatic logic [OUT_W-1:0] cvt(input logic [IN_W-1:0] v);
    return OUT_W'($signed(v) >>> SH);
  endfunction
`endif
  state_t state_q, state_d;
  logic [XW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_BOTS-1:0] cap_q, cap_d, ack_q, ack_d;
  logic pend_q, pend_d, oc_q, rise, take;
  logic [FW-1:0] stg_vx_q, stg_vx_d, stg_vy_q, stg_vy_d, stg_x_q, stg_x_d, stg_y_q, stg_y_d;
  logic [FW-1:0] o_vx_q, o_vx_d, o_vy_q, o_vy_d, o_x_q, o_x_d, o_y_q, o_y_d;
`ifdef BOT_LOADER_SAT_EN
  logic [NUM_BOTS-1:0] stg_sat_q, stg_sat_d, sat_q, sat_d;
  assign sat_flag = sat_q;
`else
  assign sat_flag = '0;
`endif
  assign rise      = output_check & ~oc_q;
  assign take      = state_q == SCAN && bot_valid[idx_q] && !cap_q[idx_q];
  assign bot_ack   = ack_q;
  assign read_done = state_q == DONE;
  assign out_vx    = o_vx_q;
  assign out_vy    = o_vy_q;
  assign out_x     = o_x_q;
  assign out_y     = o_y_q;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    ack_d    = '0;
    pend_d   = pend_q;
    stg_vx_d = stg_vx_q;
    stg_vy_d = stg_vy_q;
    stg_x_d  = stg_x_q;
    stg_y_d  = stg_y_q;
    o_vx_d   = o_vx_q;
    o_vy_d   = o_vy_q;
    o_x_d    = o_x_q;
    o_y_d    = o_y_q;
`ifdef BOT_LOADER_SAT_EN
    stg_sat_d = stg_sat_q;
    sat_d     = sat_q;
`endif
    if (take) begin
      stg_vx_d[idx_q*OUT_W +: OUT_W] = cvt(bot_vx[idx_q*IN_W +: IN_W]);
      stg_vy_d[idx_q*OUT_W +: OUT_W] = cvt(bot_vy[idx_q*IN_W +: IN_W]);
      stg_x_d[idx_q*OUT_W +: OUT_W]  = cvt(bot_x[idx_q*IN_W +: IN_W]);
      stg_y_d[idx_q*OUT_W +: OUT_W]  = cvt(bot_y[idx_q*IN_W +: IN_W]);
`ifdef BOT_LOADER_SAT_EN
      stg_sat_d[idx_q] = ovf(bot_vx[idx_q*IN_W +: IN_W]) | ovf(bot_vy[idx_q*IN_W +: IN_W])
                       | ovf(bot_x[idx_q*IN_W +: IN_W]) | ovf(bot_y[idx_q*IN_W +: IN_W]);
`endif
      cap_d[idx_q] = 1'b1;
      ack_d[idx_q] = 1'b1;
    end
    case (state_q)
      SCAN:
        if (take && &cap_d) begin
          state_d = DONE;
          cap_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          o_vx_d  = stg_vx_d;
          o_vy_d  = stg_vy_d;
          o_x_d   = stg_x_d;
          o_y_d   = stg_y_d;
`ifdef BOT_LOADER_SAT_EN
          sat_d   = stg_sat_d;
`endif
        end else idx_d = idx_q == XW'(NUM_BOTS - 1) ? '0 : idx_q + 1'b1;
      DONE: begin
        cnt_d  = cnt_q + 1'b1;
        pend_d = pend_q | rise;
        if (cnt_q == CW'(DONE_CYCLES - 1)) begin
          state_d = (pend_q | rise) ? SCAN : IDLE;
          pend_d  = 1'b0;
        end
      end
      default: state_d = rise ? SCAN : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SCAN;
      idx_q    <= '0;
      cnt_q    <= '0;
      cap_q    <= '0;
      ack_q    <= '0;
      pend_q   <= 1'b0;
      oc_q     <= 1'b0;
      stg_vx_q <= '0;
      stg_vy_q <= '0;
      stg_x_q  <= '0;
      stg_y_q  <= '0;
      o_vx_q   <= '0;
      o_vy_q   <= '0;
      o_x_q    <= '0;
      o_y_q    <= '0;
`ifdef BOT_LOADER_SAT_EN
      stg_sat_q <= '0;
      sat_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      ack_q    <= ack_d;
      pend_q   <= pend_d;
      oc_q     <= output_check;
      stg_vx_q <= stg_vx_d;
      stg_vy_q <= stg_vy_d;
      stg_x_q  <= stg_x_d;
      stg_y_q  <= stg_y_d;
      o_vx_q   <= o_vx_d;
      o_vy_q   <= o_vy_d;
      o_x_q    <= o_x_d;
      o_y_q    <= o_y_d;
`ifdef BOT_LOADER_SAT_EN
      stg_sat_q <= stg_sat_d;
      sat_q     <= sat_d;
`endif
    end
  end
endmodule
